// File: rtl/ripple_count_sequencer_if.sv
// Bundles the control, counter and sample-stream signals of ripple_count_sequencer.
// The master modport is the sequencer side; the slave modport is the environment side.
interface ripple_count_sequencer_if #(
  parameter int WIDTH = 3
);
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] mod_val;
  logic [WIDTH-1:0] cnt_q;
  logic             cnt_en;
  logic             cnt_clr;
  logic             sample_valid;
  logic             sample_ready;
  logic [WIDTH-1:0] sample_data;
  logic             tc;
  logic             busy;
  logic             err;

  modport master (
    input  start, stop, mod_val, cnt_q, sample_ready,
    output cnt_en, cnt_clr, sample_valid, sample_data, tc, busy, err
  );

  modport slave (
    output start, stop, mod_val, cnt_q, sample_ready,
    input  cnt_en, cnt_clr, sample_valid, sample_data, tc, busy, err
  );
endinterface

// File: rtl/ripple_count_sequencer.sv
// Sequencer that clears, steps and checks an external ripple counter and streams samples.
// Define RIPPLE_SEQ_ERR_HALT_EN to halt in an ERR state after a mismatching sample is accepted.
module ripple_count_sequencer #(
  parameter int WIDTH      = 3,
  parameter int SETTLE_CYC = 2
) (
  input logic                      clk,
  input logic                      rst,
  ripple_count_sequencer_if.master bus
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [SW-1:0]    S_ONE       = SW'(1);
  localparam logic [WIDTH-1:0] W_ONE       = WIDTH'(1);

`ifdef RIPPLE_SEQ_ERR_HALT_EN
  typedef enum logic [2:0] {IDLE, CLR, SETTLE, CHECK, STEP, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, CLR, SETTLE, CHECK, STEP} state_t;
`endif

  state_t           state, state_nxt;
  logic [SW-1:0]    settle_cnt, settle_nxt;
  logic [WIDTH-1:0] exp_val, exp_nxt;
  logic [WIDTH-1:0] last, last_nxt;
  logic             stop_pend, stop_nxt;
  logic             cnt_en_r, cnt_en_nxt;
  logic             cnt_clr_r, cnt_clr_nxt;
  logic             valid_r, valid_nxt;
  logic [WIDTH-1:0] data_r, data_nxt;
  logic             tc_r, tc_nxt;
  logic             busy_r, busy_nxt;
  logic             err_r, err_nxt;
  logic             accept;

  assign accept = valid_r && bus.sample_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      exp_val    <= '0;
      last       <= '0;
      stop_pend  <= 1'b0;
      cnt_en_r   <= 1'b0;
      cnt_clr_r  <= 1'b0;
      valid_r    <= 1'b0;
      data_r     <= '0;
      tc_r       <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      exp_val    <= exp_nxt;
      last       <= last_nxt;
      stop_pend  <= stop_nxt;
      cnt_en_r   <= cnt_en_nxt;
      cnt_clr_r  <= cnt_clr_nxt;
      valid_r    <= valid_nxt;
      data_r     <= data_nxt;
      tc_r       <= tc_nxt;
      busy_r     <= busy_nxt;
      err_r      <= err_nxt;
    end
  end

  // Outputs are computed one cycle ahead so every port is driven from a flop.
  always_comb begin
    state_nxt   = state;
    settle_nxt  = settle_cnt;
    exp_nxt     = exp_val;
    last_nxt    = last;
    stop_nxt    = stop_pend;
    cnt_en_nxt  = 1'b0;
    cnt_clr_nxt = 1'b0;
    valid_nxt   = valid_r;
    data_nxt    = data_r;
    tc_nxt      = 1'b0;
    busy_nxt    = busy_r;
    err_nxt     = err_r;

    if (state != IDLE && bus.stop) begin
      stop_nxt = 1'b1;
    end

    case (state)
      IDLE: begin
        if (bus.start) begin
          last_nxt    = (bus.mod_val == '0) ? '1 : bus.mod_val - W_ONE;
          exp_nxt     = '0;
          err_nxt     = 1'b0;
          stop_nxt    = 1'b0;
          cnt_clr_nxt = 1'b1;
          busy_nxt    = 1'b1;
          state_nxt   = CLR;
        end
      end

      CLR: begin
        settle_nxt = '0;
        state_nxt  = SETTLE;
      end

      STEP: begin
        settle_nxt = '0;
        state_nxt  = SETTLE;
      end

      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          valid_nxt = 1'b1;
          data_nxt  = bus.cnt_q;
          if (bus.cnt_q != exp_val) begin
            err_nxt = 1'b1;
          end
          state_nxt = CHECK;
        end else begin
          settle_nxt = settle_cnt + S_ONE;
        end
      end

      CHECK: begin
        if (accept) begin
          valid_nxt = 1'b0;
`ifdef RIPPLE_SEQ_ERR_HALT_EN
          // err can only be set in this run by the sample being accepted now.
          if (err_r) begin
            busy_nxt  = 1'b0;
            state_nxt = ERR;
          end else
`endif
          if (stop_pend || bus.stop) begin
            busy_nxt  = 1'b0;
            stop_nxt  = 1'b0;
            state_nxt = IDLE;
          end else if (exp_val == last) begin
            tc_nxt      = 1'b1;
            exp_nxt     = '0;
            cnt_clr_nxt = 1'b1;
            state_nxt   = CLR;
          end else begin
            cnt_en_nxt = 1'b1;
            exp_nxt    = exp_val + W_ONE;
            state_nxt  = STEP;
          end
        end
      end

`ifdef RIPPLE_SEQ_ERR_HALT_EN
      ERR: begin
        busy_nxt = 1'b0;
        err_nxt  = 1'b1;
        if (bus.start) begin
          last_nxt    = (bus.mod_val == '0) ? '1 : bus.mod_val - W_ONE;
          exp_nxt     = '0;
          err_nxt     = 1'b0;
          stop_nxt    = 1'b0;
          cnt_clr_nxt = 1'b1;
          busy_nxt    = 1'b1;
          state_nxt   = CLR;
        end
      end
`endif

      default: begin
        valid_nxt = 1'b0;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.cnt_en       = cnt_en_r;
  assign bus.cnt_clr      = cnt_clr_r;
  assign bus.sample_valid = valid_r;
  assign bus.sample_data  = data_r;
  assign bus.tc           = tc_r;
  assign bus.busy         = busy_r;
  assign bus.err          = err_r;

endmodule

// File: tb/tb_ripple_count_sequencer.sv
// Self-checking bench for ripple_count_sequencer with an ideal (optionally faulty) counter model.
// Expected samples come from a modulo-sequence model: sample k of a run is k mod modulus.
module tb_ripple_count_sequencer;

  localparam int W = 3;
  localparam int S = 2;

  logic clk;
  logic rst;

  ripple_count_sequencer_if #(.WIDTH(W)) bus ();

  ripple_count_sequencer #(.WIDTH(W), .SETTLE_CYC(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int mod_m  = 5;
  int seq_idx = 0;
  logic [W-1:0] stuck = '0;
  logic [W-1:0] ctr   = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal external counter: synchronous clear, step on toggle enable, optional stuck bits.
  always @(posedge clk) begin
    if (bus.cnt_clr)     ctr <= '0;
    else if (bus.cnt_en) ctr <= ctr + 1'b1;
  end
  assign bus.cnt_q = ctr & ~stuck;

  function automatic logic [W-1:0] expected_sample();
    return W'(seq_idx % mod_m) & ~stuck;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic r);
    bus.start        = s;
    bus.stop         = p;
    bus.sample_ready = r;
  endtask

  task automatic start_run(input logic [W-1:0] m);
    @(negedge clk);
    bus.mod_val = m;
    applyStimulus(1'b1, 1'b0, 1'b0);
    mod_m   = (m == '0) ? (1 << W) : int'(m);
    seq_idx = 0;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    bus.mod_val = W'($urandom);
    checkOutput("start_clr", bus.cnt_clr, 1'b1);
    checkOutput("start_busy", bus.busy, 1'b1);
    checkOutput("start_err_clear", bus.err, 1'b0);
    for (int k = 2; k <= 2 + S; k++) begin
      @(negedge clk);
      checkOutput("first_valid_latency", bus.sample_valid, (k == 2 + S));
    end
  endtask

  task automatic collect_samples(input int n, input bit rnd);
    int got = 0;
    int budget = 0;
    int gap = 0;
    bit have_prev = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_acc = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic exp_tc = 1'b0;
    logic rdy;
    while (got < n && budget < 4000) begin
      @(negedge clk);
      budget++;
      gap++;
      checkOutput("tc", bus.tc, prev_acc ? exp_tc : 1'b0);
      if (prev_valid && !prev_acc) begin
        checkOutput("hold_valid", bus.sample_valid, 1'b1);
        checkOutput("hold_data", bus.sample_data, prev_data);
        checkOutput("hold_no_en", bus.cnt_en, 1'b0);
        checkOutput("hold_no_clr", bus.cnt_clr, 1'b0);
      end
      if (bus.sample_valid && !prev_valid) begin
        checkOutput("sample_data", bus.sample_data, expected_sample());
        if (!rnd && have_prev) checkOutput("sample_period", gap, 2 + S);
        gap = 0;
        have_prev = 1'b1;
      end
      checkOutput("busy_in_run", bus.busy, 1'b1);
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.sample_ready = rdy;
      prev_acc = bus.sample_valid && rdy;
      if (prev_acc) begin
        exp_tc = ((seq_idx % mod_m) == mod_m - 1);
        seq_idx++;
        got++;
      end
      prev_valid = bus.sample_valid;
      prev_data  = bus.sample_data;
    end
    @(negedge clk);
    bus.sample_ready = 1'b0;
    checkOutput("samples_collected", got, n);
    if (prev_acc) checkOutput("tc_last", bus.tc, exp_tc);
  endtask

  task automatic wait_valid(input string tag);
    int b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (!bus.sample_valid && b < 40);
    checkOutput(tag, bus.sample_valid, 1'b1);
  endtask

  task automatic end_run();
    int b = 0;
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1);
    while (bus.busy && b < 40) begin
      @(negedge clk);
      b++;
    end
    bus.sample_ready = 1'b0;
    checkOutput("end_run_idle", bus.busy, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_cnt_en"}, bus.cnt_en, 1'b0);
    checkOutput({tag, "_cnt_clr"}, bus.cnt_clr, 1'b0);
    checkOutput({tag, "_valid"}, bus.sample_valid, 1'b0);
    checkOutput({tag, "_data"}, bus.sample_data, '0);
    checkOutput({tag, "_tc"}, bus.tc, 1'b0);
    checkOutput({tag, "_busy"}, bus.busy, 1'b0);
    checkOutput({tag, "_err"}, bus.err, 1'b0);
  endtask

  initial begin
    int m;
    rst = 1'b1;
    bus.mod_val = '0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    $display("[TB] reset");
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("after_reset");

    $display("[TB] modulus 5, ready high");
    start_run(W'(5));
    collect_samples(12, 1'b0);
    checkOutput("mod5_err", bus.err, 1'b0);
    end_run();

    $display("[TB] modulus 0, random ready");
    start_run(W'(0));
    collect_samples(9, 1'b1);
    checkOutput("mod0_err", bus.err, 1'b0);
    end_run();

    $display("[TB] modulus 1");
    start_run(W'(1));
    collect_samples(4, 1'b0);
    end_run();

    m = $urandom_range(1, 7);
    $display("[TB] random modulus %0d", m);
    start_run(W'(m));
    collect_samples(2 * m + 1, 1'b1);
    end_run();

    $display("[TB] backpressure and stop during settle");
    start_run(W'(5));
    collect_samples(2, 1'b0);
    wait_valid("hold_wait");
    checkOutput("hold_first_data", bus.sample_data, expected_sample());
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_valid", bus.sample_valid, 1'b1);
      checkOutput("bp_data", bus.sample_data, expected_sample());
      checkOutput("bp_no_en", bus.cnt_en, 1'b0);
    end
    bus.sample_ready = 1'b1;
    @(negedge clk);
    bus.sample_ready = 1'b0;
    seq_idx++;
    checkOutput("step_en", bus.cnt_en, 1'b1);
    checkOutput("step_valid_drop", bus.sample_valid, 1'b0);
    checkOutput("step_no_tc", bus.tc, 1'b0);
    @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    wait_valid("stop_sample_wait");
    checkOutput("stop_sample_data", bus.sample_data, expected_sample());
    bus.sample_ready = 1'b1;
    @(negedge clk);
    bus.sample_ready = 1'b0;
    checkOutput("stop_busy", bus.busy, 1'b0);
    checkOutput("stop_valid", bus.sample_valid, 1'b0);
    checkOutput("stop_tc", bus.tc, 1'b0);
    checkOutput("stop_en", bus.cnt_en, 1'b0);
    repeat (5) begin
      @(negedge clk);
      checkOutput("idle_clr", bus.cnt_clr, 1'b0);
      checkOutput("idle_en", bus.cnt_en, 1'b0);
      checkOutput("idle_valid", bus.sample_valid, 1'b0);
    end
    start_run(W'(5));
    collect_samples(3, 1'b1);
    end_run();

    $display("[TB] reset mid-run");
    start_run(W'(5));
    collect_samples(3, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrun_reset");
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_all_zero("post_reset_idle");
    end
    start_run(W'(5));
    collect_samples(6, 1'b0);
    end_run();

    $display("[TB] counter bit 1 stuck at 0");
    stuck = W'(2);
    start_run(W'(5));
    collect_samples(2, 1'b0);
    checkOutput("fault_err_before", bus.err, 1'b0);
    wait_valid("fault_wait");
    checkOutput("fault_data", bus.sample_data, expected_sample());
    checkOutput("fault_err", bus.err, 1'b1);
    bus.sample_ready = 1'b1;
    @(negedge clk);
    bus.sample_ready = 1'b0;
    seq_idx++;
`ifdef RIPPLE_SEQ_ERR_HALT_EN
    checkOutput("halt_busy", bus.busy, 1'b0);
    checkOutput("halt_err", bus.err, 1'b1);
    repeat (8) begin
      @(negedge clk);
      checkOutput("halt_no_en", bus.cnt_en, 1'b0);
      checkOutput("halt_no_clr", bus.cnt_clr, 1'b0);
      checkOutput("halt_no_valid", bus.sample_valid, 1'b0);
      checkOutput("halt_err_sticky", bus.err, 1'b1);
    end
    stuck = '0;
    start_run(W'(5));
    collect_samples(2, 1'b0);
    end_run();
`else
    wait_valid("continue_wait");
    checkOutput("continue_data", bus.sample_data, expected_sample());
    checkOutput("continue_err", bus.err, 1'b1);
    checkOutput("continue_busy", bus.busy, 1'b1);
    stuck = '0;
    end_run();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
